// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC waveform playback sequencer.
package dac_pkg;

  localparam int unsigned DAC_ADDR_W  = 11;
  localparam int unsigned DAC_DATA_W  = 16;
  localparam int unsigned DAC_DIV_MIN = 2;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StLoad,
    StHold
  } dac_state_e;

endpackage

// File: rtl/dac_rate_div.sv
// Reloadable sample-rate down-counter. The divider is clamped so that a
// FETCH+LOAD pair always fits inside one sample period.
module dac_rate_div
  import dac_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_clamped;
  logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    div_clamped = (div < DIV_WIDTH'(DAC_DIV_MIN)) ? DIV_WIDTH'(DAC_DIV_MIN) : div;
  end

  always_comb begin
    div_lat_d = div_lat_q;
    cnt_d     = cnt_q;
    if (load) begin
      div_lat_d = div_clamped;
      cnt_d     = div_clamped;
    end else if (enable) begin
      cnt_d = (cnt_q == '0) ? div_lat_q : cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_lat_q <= DIV_WIDTH'(DAC_DIV_MIN);
      cnt_q     <= '0;
    end else begin
      div_lat_q <= div_lat_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == '0);

endmodule

// File: rtl/dac_wave_player.sv
// Playback sequencer: walks a RAM address window at a programmed rate and
// hands each sample to the DAC serializer over valid/ready.
module dac_wave_player
  import dac_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DAC_ADDR_W,
  parameter int unsigned DATA_WIDTH = DAC_DATA_W,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_end_addr,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic                  cfg_loop,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] smp_data,
  output logic                  smp_valid,
  input  logic                  smp_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  dac_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic                  loop_q, loop_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] smp_data_q, smp_data_d;
  logic                  smp_valid_q, smp_valid_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;

  logic tick;
  logic start_accept;
  logic unaccepted;
  logic at_end;

  assign start_accept = (state_q == StIdle) && cmd_start && !cmd_stop;
  // A sample handed over in the very cycle of the tick counts as accepted.
  assign unaccepted   = smp_valid_q && !smp_ready;
  assign at_end       = (ptr_q == end_q);

  dac_rate_div #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (busy),
    .load   (start_accept),
    .div    (cfg_div),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_accept) state_d = StFetch;
      StFetch: state_d = StLoad;
      StLoad:  state_d = StHold;
      StHold: begin
        if (tick && !unaccepted) begin
          state_d = last_q ? StIdle : StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
    if (cmd_stop) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    start_d     = start_q;
    end_d       = end_q;
    loop_d      = loop_q;
    last_d      = last_q;
    smp_data_d  = smp_data_q;
    smp_valid_d = smp_valid_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_accept) begin
          ptr_d   = cfg_start_addr;
          start_d = cfg_start_addr;
          end_d   = cfg_end_addr;
          loop_d  = cfg_loop;
          last_d  = 1'b0;
        end
      end
      StFetch: ;
      StLoad: begin
        smp_data_d  = ram_dout;
        smp_valid_d = 1'b1;
        last_d      = at_end && !loop_q;
        ptr_d       = at_end ? start_q : ptr_q + ADDR_WIDTH'(1);
      end
      StHold: begin
        if (smp_valid_q && smp_ready) begin
          smp_valid_d = 1'b0;
        end
        if (tick) begin
          if (unaccepted) begin
            underrun_d = 1'b1;
          end else if (last_q) begin
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (cmd_stop) begin
      smp_valid_d = 1'b0;
      done_d      = 1'b0;
      underrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      start_q     <= '0;
      end_q       <= '0;
      loop_q      <= 1'b0;
      last_q      <= 1'b0;
      smp_data_q  <= '0;
      smp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      start_q     <= start_d;
      end_q       <= end_d;
      loop_q      <= loop_d;
      last_q      <= last_d;
      smp_data_q  <= smp_data_d;
      smp_valid_q <= smp_valid_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ram_addr  = ptr_q;
  assign ram_we    = 1'b0;
  assign smp_data  = smp_data_q;
  assign smp_valid = smp_valid_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_dac_wave_player.sv
// Scoreboard bench for dac_wave_player with a synchronous-read RAM model.
module tb_dac_wave_player;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;
  localparam int unsigned VW = 16;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] cfg_start_addr;
  logic [AW-1:0] cfg_end_addr;
  logic [VW-1:0] cfg_div;
  logic          cfg_loop;
  logic          cmd_start;
  logic          cmd_stop;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] smp_data;
  logic          smp_valid;
  logic          smp_ready;
  logic          busy;
  logic          done;
  logic          underrun;

  dac_wave_player u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_start_addr (cfg_start_addr),
    .cfg_end_addr   (cfg_end_addr),
    .cfg_div        (cfg_div),
    .cfg_loop       (cfg_loop),
    .cmd_start      (cmd_start),
    .cmd_stop       (cmd_stop),
    .ram_addr       (ram_addr),
    .ram_we         (ram_we),
    .ram_dout       (ram_dout),
    .smp_data       (smp_data),
    .smp_valid      (smp_valid),
    .smp_ready      (smp_ready),
    .busy           (busy),
    .done           (done),
    .underrun       (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return DW'(a) * 16'd7 + 16'h0101;
  endfunction

  always @(posedge clk) ram_dout <= ram_word(ram_addr);

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  int done_cnt   = 0;
  int und_cnt    = 0;
  int last_acc   = -1;
  int exp_period = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (smp_valid && smp_ready) begin
        check_eq("sb_has_entry", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check_eq("smp", 32'(smp_data), 32'(exp_q.pop_front()));
        if (exp_period != 0 && last_acc >= 0) check_eq("period", cyc - last_acc, exp_period);
        last_acc = cyc;
      end
      if (done) done_cnt++;
      if (underrun) und_cnt++;
      if (done || underrun) check_eq("done_und_excl", 32'(done && underrun), 0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic play(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [VW-1:0] d,
                      input logic lp, input int n, output int sc);
    logic [AW-1:0] a;
    a = s;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ram_word(a));
      a = (a == e) ? s : a + 11'd1;
    end
    cfg_start_addr = s;
    cfg_end_addr   = e;
    cfg_div        = d;
    cfg_loop       = lp;
    cmd_start      = 1'b1;
    sc             = cyc;
    step(1);
    cmd_start      = 1'b0;
  endtask

  task automatic wait_sb_empty(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    check_eq("sb_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step(1);
      k++;
    end
    check_eq("idle", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int c0;
    int d0;
    int u0;
    int k;
    rst_n = 1'b0;
    cfg_start_addr = '0;
    cfg_end_addr = '0;
    cfg_div = '0;
    cfg_loop = 1'b0;
    cmd_start = 1'b0;
    cmd_stop = 1'b0;
    smp_ready = 1'b1;
    step(3);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_valid", 32'(smp_valid), 0);
    check_eq("rst_data", 32'(smp_data), 0);
    check_eq("rst_addr", 32'(ram_addr), 0);
    check_eq("rst_pulses", 32'({done, underrun}), 0);
    check_eq("ram_we", 32'(ram_we), 0);
    rst_n = 1'b1;
    step(2);

    // 1: one-shot window, first-sample latency, steady period, done pulse
    exp_period = 4; last_acc = -1; d0 = done_cnt;
    play(11'd4, 11'd7, 16'd3, 1'b0, 4, c0);
    k = 0;
    while (!smp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("first_lat", cyc - c0, 3);
    wait_sb_empty(40);
    wait_idle(20);
    step(2);
    check_eq("t1_done", done_cnt - d0, 1);

    // 2: looping window that wraps through the top of the address space
    exp_period = 6; last_acc = -1; d0 = done_cnt;
    play(11'd2045, 11'd1, 16'd5, 1'b1, 7, c0);
    wait_sb_empty(100);
    cmd_stop = 1'b1;
    step(1);
    cmd_stop = 1'b0;
    check_eq("stop_valid", 32'(smp_valid), 0);
    check_eq("stop_busy", 32'(busy), 0);
    step(3);
    check_eq("stop_no_done", done_cnt - d0, 0);

    // 3: backpressure on the sixth sample
    exp_period = 0; d0 = done_cnt;
    play(11'd10, 11'd17, 16'd3, 1'b0, 8, c0);
    k = 0;
    while (exp_q.size() > 3 && k < 60) begin
      step(1);
      k++;
    end
    smp_ready = 1'b0;
    u0 = und_cnt;
    step(10);
    smp_ready = 1'b1;
    wait_sb_empty(60);
    wait_idle(20);
    step(2);
    check_eq("t3_underruns", und_cnt - u0, 2);
    check_eq("t3_done", done_cnt - d0, 1);

    // 4: clamped dividers, config changes during playback ignored
    exp_period = 3; last_acc = -1; d0 = done_cnt;
    play(11'd20, 11'd23, 16'd0, 1'b0, 4, c0);
    wait_sb_empty(40);
    wait_idle(20);
    last_acc = -1;
    play(11'd40, 11'd43, 16'd1, 1'b0, 4, c0);
    step(2);
    cfg_div = 16'd50; cfg_start_addr = 11'd0; cfg_end_addr = 11'd100; cfg_loop = 1'b1;
    wait_sb_empty(40);
    wait_idle(20);
    step(2);
    check_eq("t4_done", done_cnt - d0, 2);

    // 5: start+stop together, start while busy, single-sample window
    cmd_start = 1'b1; cmd_stop = 1'b1;
    step(1);
    cmd_start = 1'b0; cmd_stop = 1'b0;
    check_eq("ss_busy0", 32'(busy), 0);
    step(3);
    check_eq("ss_busy1", 32'(busy), 0);
    exp_period = 4; last_acc = -1; d0 = done_cnt;
    play(11'd30, 11'd33, 16'd3, 1'b0, 4, c0);
    step(4);
    cfg_start_addr = 11'd100; cfg_end_addr = 11'd100; cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    wait_sb_empty(40);
    wait_idle(20);
    step(2);
    check_eq("t5_busy_start", done_cnt - d0, 1);
    last_acc = -1; d0 = done_cnt;
    play(11'd9, 11'd9, 16'd3, 1'b0, 1, c0);
    wait_idle(30);
    step(4);
    check_eq("t5_single_done", done_cnt - d0, 1);
    wait_sb_empty(1);

    // 6: asynchronous reset while a sample is held
    exp_period = 0; smp_ready = 1'b0;
    play(11'd50, 11'd60, 16'd7, 1'b1, 0, c0);
    k = 0;
    while (!smp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("t6_valid", 32'(smp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_valid", 32'(smp_valid), 0);
    check_eq("arst_data", 32'(smp_data), 0);
    check_eq("arst_addr", 32'(ram_addr), 0);
    check_eq("arst_pulses", 32'({done, underrun}), 0);
    step(2);
    rst_n = 1'b1;
    smp_ready = 1'b1;
    step(1);
    exp_period = 4; last_acc = -1; d0 = done_cnt;
    play(11'd5, 11'd6, 16'd3, 1'b0, 2, c0);
    wait_sb_empty(40);
    wait_idle(20);
    step(2);
    check_eq("t6_done", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
